// File: rtl/fifo_wr_packer_if.sv
// rtl/fifo_wr_packer_if.sv - byte stream in and FIFO write port out of the write-side packer
interface fifo_wr_packer_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
);
    logic [IN_WIDTH-1:0]  s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic                 fifo_full;
    logic [OUT_WIDTH-1:0] wr_data;
    logic                 wr_en;

    modport master (
        output s_data, s_valid, s_last, fifo_full,
        input  s_ready, wr_data, wr_en
    );

    modport slave (
        input  s_data, s_valid, s_last, fifo_full,
        output s_ready, wr_data, wr_en
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// rtl/fifo_wr_packer.sv - packs a narrow byte stream into FIFO words for the A->B crossing FIFO
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 a_clk_i,
    input  logic                 aresetn_i,
    fifo_wr_packer_if.slave      bus,
    output logic [CNT_WIDTH-1:0] words_cnt_o
);
    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int IDX_W = $clog2(RATIO);

    if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_wr_packer: OUT_WIDTH must be a multiple (>=2) of IN_WIDTH");
    end

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 accept;
    logic                 completing;
    logic                 wr_en;
    logic [OUT_WIDTH-1:0] merged;

    // A held word only blocks new beats while the FIFO cannot take it.
    assign wr_en      = out_valid_q & ~bus.fifo_full;
    assign accept     = bus.s_valid & bus.s_ready;
    assign completing = accept & ((idx_q == IDX_W'(RATIO - 1)) | bus.s_last);

    assign bus.s_ready = ~out_valid_q | ~bus.fifo_full;
    assign bus.wr_en   = wr_en;
    assign bus.wr_data = out_q;
    assign words_cnt_o = cnt_q;

    always_comb begin
        merged = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(idx_q)) begin
                merged[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
            end else if (k == int'(idx_q)) begin
                merged[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
            end else begin
                merged[k*IN_WIDTH +: IN_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q + CNT_WIDTH'(wr_en);

        if (wr_en) begin
            out_valid_d = 1'b0;
        end

        // A completing beat in the same cycle as a write reloads the output stage.
        if (completing) begin
            out_d       = merged;
            out_valid_d = 1'b1;
            acc_d       = '0;
            idx_d       = '0;
        end else if (accept) begin
            acc_d[idx_q*IN_WIDTH +: IN_WIDTH] = bus.s_data;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge a_clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb/tb_fifo_wr_packer.sv - randomized self-checking bench for fifo_wr_packer
module tb_fifo_wr_packer;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] words_cnt;

    fifo_wr_packer_if #(.IN_WIDTH(8), .OUT_WIDTH(32)) bus ();

    fifo_wr_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .CNT_WIDTH(16)) dut (
        .a_clk_i     (clk),
        .aresetn_i   (aresetn),
        .bus         (bus.slave),
        .words_cnt_o (words_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  lane_bytes[$];
    logic [31:0] exp_q[$];
    logic [15:0] model_cnt = 16'd0;
    bit          rand_full = 1'b0;
    bit          ready_low_seen = 1'b0;
    bit          pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: bytes collect into a word, little-endian, closed by 4 bytes or by last.
    task automatic model_beat(input logic [7:0] d, input bit last);
        logic [31:0] w;
        lane_bytes.push_back(d);
        if (last || lane_bytes.size() == 4) begin
            w = 32'd0;
            foreach (lane_bytes[i]) w = w + (32'(lane_bytes[i]) << (8 * i));
            exp_q.push_back(w);
            lane_bytes.delete();
        end
    endtask

    always @(negedge clk) begin
        if (aresetn) begin
            pend = (exp_q.size() != 0);
            check("s_ready", 64'(bus.s_ready), 64'(!(pend && bus.fifo_full)));
            check("wr_en", 64'(bus.wr_en), 64'(pend && !bus.fifo_full));
            check("words_cnt", 64'(words_cnt), 64'(model_cnt));
            if (bus.wr_en) begin
                if (pend) begin
                    check("wr_data", 64'(bus.wr_data), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                model_cnt = model_cnt + 16'd1;
            end
            if (!bus.s_ready) ready_low_seen = 1'b1;
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit last);
        bit done = 1'b0;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = bus.s_ready;
            @(posedge clk);
            #1;
            if (done) model_beat(d, last);
            else if (rand_full) bus.fifo_full = ($urandom_range(0, 2) == 0);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        if (rand_full) bus.fifo_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        bus.fifo_full = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = (exp_q.size() == 0);
        end
        if (!ok) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        lane_bytes.delete();
        exp_q.delete();
        model_cnt = 16'd0;
        #2;
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_words_cnt", 64'(words_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] n_fill;
        bus.s_data    = 8'd0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.fifo_full = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        @(negedge clk);
        check("t1_wr_en", 64'(bus.wr_en), 64'd1);
        check("t1_wr_data", 64'(bus.wr_data), 64'h44332211);
        @(negedge clk);
        check("t1_words_cnt", 64'(words_cnt), 64'd1);
        @(posedge clk);
        #1;

        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        send_beat(8'hCC, 1'b1);
        drain();

        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        bus.fifo_full = 1'b1;
        send_beat(8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_wr_en", 64'(bus.wr_en), 64'd0);
            check("t4_stall_ready", 64'(bus.s_ready), 64'd0);
            check("t4_stall_data", 64'(bus.wr_data), 64'h04030201);
        end
        @(posedge clk);
        #1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("t4_release_wr_en", 64'(bus.wr_en), 64'd1);
        @(negedge clk);
        check("t4_after_ready", 64'(bus.s_ready), 64'd1);
        check("t4_after_wr_en", 64'(bus.wr_en), 64'd0);
        check("t4_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        send_beat(8'h99, 1'b0);
        send_beat(8'h9A, 1'b0);
        do_reset();
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b0);
        send_beat(8'h77, 1'b0);
        send_beat(8'h88, 1'b0);
        @(negedge clk);
        check("t5_wr_data", 64'(bus.wr_data), 64'h88776655);
        @(posedge clk);
        #1;
        drain();
        check("t5_words_cnt", 64'(words_cnt), 64'd1);

        ready_low_seen = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(8'hC0 + i), 1'b0);
        drain();
        check("t6_ready_never_low", 64'(ready_low_seen), 64'd0);
        check("t6_words_cnt", 64'(words_cnt), 64'd3);

        rand_full = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            send_beat(8'($urandom), ($urandom_range(0, 5) == 0));
        end
        send_beat(8'hEE, 1'b1);
        rand_full = 1'b0;
        drain();

        n_fill = 16'hFFFF - model_cnt;
        for (int i = 0; i < int'(n_fill); i++) send_beat(8'($urandom), 1'b1);
        drain();
        check("wrap_pre", 64'(words_cnt), 64'hFFFF);
        send_beat(8'h5A, 1'b1);
        drain();
        check("wrap_zero", 64'(words_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
